// File: rtl/button_conditioner_pkg.sv
// Shared types and default constants for the push-button conditioner.
// Used by button_conditioner and any logic that inspects its debounce state.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BTN_DEBOUNCE_DEFAULT      = 50000;    // 1 ms at 50 MHz
    localparam int BTN_SYNC_STAGES_DEFAULT   = 2;
    localparam int BTN_REPEAT_DELAY_DEFAULT  = 25000000;
    localparam int BTN_REPEAT_PERIOD_DEFAULT = 10000000;

    function automatic int btnMax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// Reusable for any slow asynchronous level signal entering the clk domain.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] syncReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncReg <= '0;
        end else begin
            syncReg <= {syncReg[STAGES-2:0], d};
        end
    end

    assign q = syncReg[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a raw push-button; emits a debounced level plus press/release strobes.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while the button stays held.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = BTN_SYNC_STAGES_DEFAULT,
    parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic             s;
    btn_state_t       stateReg, stateNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic             countDone;
    logic             pressEvt, releaseEvt, repeatEvt;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) uSync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s)
    );

    assign countDone = (cntReg == CNT_LAST);

    // The cycle that enters a wait state clears the counter; each further cycle of
    // the new level counts, so acceptance lands SYNC_STAGES + DEBOUNCE_CYCLES edges
    // after the input edge is first sampled.
    always_comb begin
        stateNext  = stateReg;
        cntNext    = cntReg;
        pressEvt   = 1'b0;
        releaseEvt = 1'b0;
        unique case (stateReg)
            IDLE: begin
                if (s) begin
                    stateNext = PRESS_WAIT;
                    cntNext   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (countDone) begin
                    stateNext = HELD;
                    cntNext   = '0;
                    pressEvt  = 1'b1;
                end else if (cntReg != CNT_MAX) begin
                    cntNext = cntReg + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    stateNext = RELEASE_WAIT;
                    cntNext   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    stateNext = HELD;
                    cntNext   = '0;
                end else if (countDone) begin
                    stateNext  = IDLE;
                    cntNext    = '0;
                    releaseEvt = 1'b1;
                end else if (cntReg != CNT_MAX) begin
                    cntNext = cntReg + 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(btnMax(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rptCntReg;
    logic             rptPhaseReg;   // 0: waiting out the initial delay, 1: periodic repeats
    logic             stayHeld;

    assign stayHeld  = (stateReg == HELD) && s;
    assign repeatEvt = stayHeld && (rptCntReg == (rptPhaseReg ? PERIOD_LAST : DELAY_LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptCntReg   <= '0;
            rptPhaseReg <= 1'b0;
        end else if (!stayHeld) begin
            rptCntReg   <= '0;
            rptPhaseReg <= 1'b0;
        end else if (repeatEvt) begin
            rptCntReg   <= '0;
            rptPhaseReg <= 1'b1;
        end else begin
            rptCntReg <= rptCntReg + 1'b1;
        end
    end
`else
    assign repeatEvt = 1'b0;

    // Repeat parameters stay on the interface so both builds share one instantiation.
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gRepeatUnused
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg      <= IDLE;
            cntReg        <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            cntReg        <= cntNext;
            press_pulse   <= pressEvt | repeatEvt;
            release_pulse <= releaseEvt;
            if (pressEvt) begin
                btn_level <= 1'b1;
            end else if (releaseEvt) begin
                btn_level <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: table-driven segments plus hand-written reset,
// auto-repeat and turn-FSM sequences, with pulse timing checked through scoreboard queues.
module tb_button_conditioner;

    localparam int DEB        = 4;
    localparam int SYNC       = 2;
    localparam int RPT_DELAY  = 8;
    localparam int RPT_PERIOD = 3;
    // Inputs change just after edge c, so the sampling edge is c+1 and the
    // accepted transition lands on edge c+1+SYNC+DEB.
    localparam int LAT = SYNC + DEB + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level, press_pulse, release_pulse;
    logic z;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int pressQ[$];
    int relQ[$];

    typedef struct {
        logic  btn;
        int    hold;
        logic  expLevel;
        logic  expPress;
        logic  expRel;
        string name;
    } vec_t;

    vec_t vecs[13];

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC),
        .REPEAT_DELAY    (RPT_DELAY),
        .REPEAT_PERIOD   (RPT_PERIOD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Turn-toggle FSM driven by press_pulse on its E input.
    always @(posedge clk or posedge reset) begin
        if (reset) z <= 1'b0;
        else if (press_pulse) z <= ~z;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("[TB] ok   %s = %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic pushPress(input int c, input int hold);
        pressQ.push_back(c + LAT);
`ifdef BTN_AUTOREPEAT_EN
        // HELD keeps seeing s=1 up to edge c+hold+2 before the release reaches the FSM.
        for (int e = c + LAT + RPT_DELAY; e <= c + hold + 2; e += RPT_PERIOD)
            pressQ.push_back(e);
`endif
    endtask

    task automatic runSeg(input vec_t v);
        int c;
        btn_in = v.btn;
        c = cyc;
        if (v.expPress) pushPress(c, v.hold);
        if (v.expRel) relQ.push_back(c + LAT);
        repeat (v.hold) @(posedge clk);
        #1;
        check({v.name, " btn_level"}, int'(btn_level), int'(v.expLevel));
    endtask

    initial begin
        int c;

        vecs[0]  = '{1'b0,  6, 1'b0, 1'b0, 1'b0, "idle"};
        vecs[1]  = '{1'b1, 12, 1'b1, 1'b1, 1'b0, "clean press"};
        vecs[2]  = '{1'b0, 10, 1'b0, 1'b0, 1'b1, "clean release"};
        vecs[3]  = '{1'b1,  2, 1'b0, 1'b0, 1'b0, "bounce 1a"};
        vecs[4]  = '{1'b0,  2, 1'b0, 1'b0, 1'b0, "bounce 0a"};
        vecs[5]  = '{1'b1,  2, 1'b0, 1'b0, 1'b0, "bounce 1b"};
        vecs[6]  = '{1'b0, 12, 1'b0, 1'b0, 1'b0, "bounce settle"};
        vecs[7]  = '{1'b1,  3, 1'b0, 1'b0, 1'b0, "short press"};
        vecs[8]  = '{1'b0,  8, 1'b0, 1'b0, 1'b0, "short settle"};
        vecs[9]  = '{1'b1, 12, 1'b1, 1'b1, 1'b0, "press two"};
        vecs[10] = '{1'b0,  3, 1'b1, 1'b0, 1'b0, "release glitch"};
        vecs[11] = '{1'b1,  8, 1'b1, 1'b0, 1'b0, "back to held"};
        vecs[12] = '{1'b0, 10, 1'b0, 1'b0, 1'b1, "release two"};

        // Pulse monitor: every strobe must match the head of its scoreboard queue.
        fork
            begin : monitor
                logic prevLevel;
                prevLevel = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!reset) begin
                        if (press_pulse && release_pulse)
                            check("pulse overlap", 1, 0);
                        if (press_pulse) begin
                            if (pressQ.size() == 0) check("unexpected press_pulse at cycle", cyc, -1);
                            else check("press_pulse cycle", cyc, pressQ.pop_front());
                        end
                        if (release_pulse) begin
                            if (relQ.size() == 0) check("unexpected release_pulse at cycle", cyc, -1);
                            else check("release_pulse cycle", cyc, relQ.pop_front());
                        end
                        if (btn_level != prevLevel)
                            check("level change with strobe",
                                  int'(btn_level ? press_pulse : release_pulse), 1);
                    end
                    prevLevel = btn_level;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset btn_level", int'(btn_level), 0);
        check("reset press_pulse", int'(press_pulse), 0);
        check("reset release_pulse", int'(release_pulse), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) runSeg(vecs[i]);

        // Reset one cycle after s rises (FSM in PRESS_WAIT), button kept held.
        btn_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset in PRESS_WAIT btn_level", int'(btn_level), 0);
        check("reset in PRESS_WAIT press_pulse", int'(press_pulse), 0);
        check("reset in PRESS_WAIT release_pulse", int'(release_pulse), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        c = cyc;
        pushPress(c, 12);
        repeat (12) @(posedge clk);
        #1;
        check("press after reset btn_level", int'(btn_level), 1);

        // Reset while HELD drops the level at once; still-held button is a fresh press.
        reset = 1'b1;
        #1;
        check("reset in HELD btn_level", int'(btn_level), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        c = cyc;
        pushPress(c, 12);
        repeat (12) @(posedge clk);
        #1;
        check("re-press after reset btn_level", int'(btn_level), 1);
        runSeg('{1'b0, 10, 1'b0, 1'b0, 1'b1, "release after reset"});

        // Long hold: one pulse by default, acceptance +8,+11,+14,+17,+20 with auto-repeat.
        runSeg('{1'b1, 26, 1'b1, 1'b1, 1'b0, "long hold"});
        runSeg('{1'b0, 10, 1'b0, 1'b0, 1'b1, "long hold release"});

        // Integration with the turn FSM: two clean presses toggle z 0 -> 1 -> 0.
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("turn fsm z after reset", int'(z), 0);
        reset = 1'b0;
        runSeg('{1'b1, 12, 1'b1, 1'b1, 1'b0, "turn press 1"});
        check("turn fsm z after press 1", int'(z), 1);
        runSeg('{1'b0, 10, 1'b0, 1'b0, 1'b1, "turn release 1"});
        runSeg('{1'b1, 12, 1'b1, 1'b1, 1'b0, "turn press 2"});
        check("turn fsm z after press 2", int'(z), 0);
        runSeg('{1'b0, 10, 1'b0, 1'b0, 1'b1, "turn release 2"});

        repeat (4) @(posedge clk);
        #1;
        check("missing press pulses", pressQ.size(), 0);
        check("missing release pulses", relQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
